// File: rtl/uart_tx_arbiter_if.sv
// ============================================================================
// Module   : uart_tx_arbiter_if
// Brief    : Requester / transmitter signal bundle for uart_tx_arbiter.
//            The req_lock vector exists only when UART_TX_ARBITER_LOCK_EN
//            is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_arbiter_if #(
   parameter int NUM_CH = 4
);
   logic [NUM_CH-1:0]   req_valid;
   logic [8*NUM_CH-1:0] req_data;
   logic [NUM_CH-1:0]   req_ready;
   logic                tx_enable;
   logic [7:0]          tx_data;
   logic                tx_busy;
   logic [2:0]          grant_ch;
   logic                arb_busy;
`ifdef UART_TX_ARBITER_LOCK_EN
   logic [NUM_CH-1:0]   req_lock;
`endif

   // Requester / transmitter side: drives requests and the busy flag.
   modport master (
`ifdef UART_TX_ARBITER_LOCK_EN
      output req_lock,
`endif
      output req_valid, req_data, tx_busy,
      input  req_ready, tx_enable, tx_data, grant_ch, arb_busy
   );

   // Arbiter side.
   modport slave (
`ifdef UART_TX_ARBITER_LOCK_EN
      input  req_lock,
`endif
      input  req_valid, req_data, tx_busy,
      output req_ready, tx_enable, tx_data, grant_ch, arb_busy
   );
endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin arbiter feeding bytes from NUM_CH requesters into a
//            single UART transmitter. Optional feature macro
//            UART_TX_ARBITER_LOCK_EN adds req_lock, which lets the channel
//            that won last keep winning while it holds lock and valid.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
   parameter int NUM_CH = 4
) (
   input wire logic          clk,
   input wire logic          reset,
   uart_tx_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ISSUE     = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

   localparam logic [1:0] C_TIMEOUT_LAST = 2'd3;

   state_t      r_state;
   state_t      w_next_state;
   logic [7:0]  r_data;
   logic [2:0]  r_last_grant;
   logic [2:0]  r_grant_ch;
   logic [1:0]  r_to_cnt;
   logic        r_rst_hold;

   logic [7:0]        w_valid_ext;
   logic [3:0]        w_cand;
   logic              w_found;
   logic [2:0]        w_winner;
   logic [7:0]        w_win_data;
   logic              w_grant;
   logic [NUM_CH-1:0] w_ready;
   logic              w_tx_enable;
`ifdef UART_TX_ARBITER_LOCK_EN
   logic [7:0]        w_lock_ext;
`endif

   // Round-robin winner search starting after the last granted channel.
   always_comb begin
      w_valid_ext               = '0;
      w_valid_ext[NUM_CH-1:0]   = bus.req_valid;
      w_found                   = 1'b0;
      w_winner                  = r_last_grant;
      w_cand                    = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         w_cand = {1'b0, r_last_grant} + 4'(k);
         if (w_cand >= 4'(NUM_CH)) begin
            w_cand = w_cand - 4'(NUM_CH);
         end
         if (!w_found && w_valid_ext[w_cand[2:0]]) begin
            w_found  = 1'b1;
            w_winner = w_cand[2:0];
         end
      end
`ifdef UART_TX_ARBITER_LOCK_EN
      // A locked, still-valid previous winner overrides the rotation.
      w_lock_ext               = '0;
      w_lock_ext[NUM_CH-1:0]   = bus.req_lock;
      if (w_lock_ext[r_last_grant] && w_valid_ext[r_last_grant]) begin
         w_found  = 1'b1;
         w_winner = r_last_grant;
      end
`endif
   end

   // Byte of the winning channel.
   always_comb begin
      w_win_data = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (w_winner == 3'(i)) begin
            w_win_data = bus.req_data[8*i +: 8];
         end
      end
   end

   // Grant qualification; suppressed during reset and the release cycle.
   always_comb begin
      w_grant = (r_state == S_IDLE) && !bus.tx_busy && w_found
                && !reset && !r_rst_hold;
      w_ready = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_ready[i] = w_grant && (w_winner == 3'(i));
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and strobe decode.
   always_comb begin
      w_next_state = r_state;
      w_tx_enable  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_grant) begin
               w_next_state = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_tx_enable  = 1'b1;
            w_next_state = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (bus.tx_busy) begin
               w_next_state = S_WAIT_DONE;
            end else if (r_to_cnt == C_TIMEOUT_LAST) begin
               w_next_state = S_IDLE;
            end
         end
         S_WAIT_DONE: begin
            if (!bus.tx_busy) begin
               w_next_state = S_IDLE;
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Capture the winner's byte and index on the grant cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_data       <= '0;
         r_last_grant <= 3'(NUM_CH - 1);
         r_grant_ch   <= '0;
         r_rst_hold   <= 1'b1;
      end else begin
         r_rst_hold <= 1'b0;
         if (w_grant) begin
            r_data       <= w_win_data;
            r_last_grant <= w_winner;
            r_grant_ch   <= w_winner;
         end
      end
   end

   // Counts idle cycles in WAIT_BUSY; a lost byte is abandoned after four.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_to_cnt <= '0;
      end else if (r_state == S_ISSUE) begin
         r_to_cnt <= '0;
      end else if (r_state == S_WAIT_BUSY && !bus.tx_busy) begin
         r_to_cnt <= r_to_cnt + 2'd1;
      end
   end

   assign bus.req_ready = w_ready;
   assign bus.tx_enable = w_tx_enable;
   assign bus.tx_data   = r_data;
   assign bus.grant_ch  = r_grant_ch;
   assign bus.arb_busy  = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Directed self-checking bench for uart_tx_arbiter (NUM_CH=4).
//            Lock scenario runs only when UART_TX_ARBITER_LOCK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

   localparam int NUM_CH = 4;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   uart_tx_arbiter_if #(.NUM_CH(NUM_CH)) bus ();

   uart_tx_arbiter #(.NUM_CH(NUM_CH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Entered at the start of an IDLE cycle; one full frame with a
   // well-behaved transmitter. req_valid stays as given throughout.
   task automatic run_frame(input logic [3:0] valid, input int ch, input logic [7:0] exp_data);
      bus.req_valid = valid;
      #1;
      check("ready_onehot", 32'(bus.req_ready), 32'(1) << ch);
      tick();
      #1;
      check("issue_en",   32'(bus.tx_enable), 32'd1);
      check("issue_data", 32'(bus.tx_data),   32'(exp_data));
      check("grant_ch",   32'(bus.grant_ch),  32'(ch));
      check("issue_rdy0", 32'(bus.req_ready), 32'd0);
      tick();
      #1;
      check("wb_en0",   32'(bus.tx_enable), 32'd0);
      check("wb_busy",  32'(bus.arb_busy),  32'd1);
      bus.tx_busy = 1'b1;
      tick();
      #1;
      check("wd_en0",   32'(bus.tx_enable), 32'd0);
      check("wd_rdy0",  32'(bus.req_ready), 32'd0);
      check("wd_busy",  32'(bus.arb_busy),  32'd1);
      bus.tx_busy = 1'b0;
      tick();
      #1;
      check("idle_back", 32'(bus.arb_busy), 32'd0);
   endtask

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      reset         = 1'b1;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.tx_busy   = 1'b0;
`ifdef UART_TX_ARBITER_LOCK_EN
      bus.req_lock  = '0;
`endif

      // Reset state with requests pending.
      tick();
      bus.req_valid = 4'b1111;
      bus.req_data  = 32'h13121110;
      #1;
      check("rst_ready", 32'(bus.req_ready), 32'd0);
      check("rst_en",    32'(bus.tx_enable), 32'd0);
      check("rst_abusy", 32'(bus.arb_busy),  32'd0);
      check("rst_data",  32'(bus.tx_data),   32'd0);
      check("rst_grant", 32'(bus.grant_ch),  32'd0);
      tick();

      // Release cycle: no ready even with valid high.
      bus.req_valid = 4'b0100;
      bus.req_data  = 32'h005A0000;
      reset         = 1'b0;
      #1;
      check("release_rdy0", 32'(bus.req_ready), 32'd0);
      tick();

      // Single request on ch2.
      run_frame(4'b0100, 2, 8'h5A);
      bus.req_valid = '0;

      // Reset in WAIT_DONE: ch1 frame from last=2.
      bus.req_data  = 32'h13121110;
      bus.req_valid = 4'b0010;
      #1;
      check("mid_ready", 32'(bus.req_ready), 32'b0010);
      tick();
      #1;
      check("mid_grant", 32'(bus.grant_ch), 32'd1);
      bus.req_valid = '0;
      tick();
      bus.tx_busy = 1'b1;
      tick();
      #1;
      check("mid_wd_busy", 32'(bus.arb_busy), 32'd1);
      reset         = 1'b1;
      bus.req_valid = 4'b1111;
      bus.tx_busy   = 1'b0;
      #1;
      check("mid_rst_en",    32'(bus.tx_enable), 32'd0);
      check("mid_rst_rdy",   32'(bus.req_ready), 32'd0);
      check("mid_rst_abusy", 32'(bus.arb_busy),  32'd0);
      check("mid_rst_data",  32'(bus.tx_data),   32'd0);
      tick();
      reset = 1'b0;
      #1;
      check("mid_release_rdy0", 32'(bus.req_ready), 32'd0);
      tick();

      // All channels contend: 0,1,2,3,0 (first also shows ch0 wins after reset).
      run_frame(4'b1111, 0, 8'h10);
      run_frame(4'b1111, 1, 8'h11);
      run_frame(4'b1111, 2, 8'h12);
      run_frame(4'b1111, 3, 8'h13);
      run_frame(4'b1111, 0, 8'h10);

      // Wrap-around: make ch3 the last grant, then ch0 precedes ch3.
      run_frame(4'b1000, 3, 8'h13);
      run_frame(4'b1001, 0, 8'h10);
      run_frame(4'b1001, 3, 8'h13);
      bus.req_valid = '0;

      // Timeout: transmitter never raises busy.
      bus.req_valid = 4'b0100;
      #1;
      check("to_ready", 32'(bus.req_ready), 32'b0100);
      tick();
      #1;
      check("to_issue", 32'(bus.tx_enable), 32'd1);
      tick();
      for (int i = 0; i < 4; i++) begin
         #1;
         check("to_wait_busy", 32'(bus.arb_busy),  32'd1);
         check("to_wait_rdy0", 32'(bus.req_ready), 32'd0);
         tick();
      end
      #1;
      check("to_idle",      32'(bus.arb_busy),  32'd0);
      check("to_next_rdy",  32'(bus.req_ready), 32'b0100);
      bus.req_valid = '0;
      tick();
      #1;
      check("to_no_grant", 32'(bus.arb_busy), 32'd0);

`ifdef UART_TX_ARBITER_LOCK_EN
      // Lock: last=2, so ch0 then ch1; ch1 then repeats while locked.
      bus.req_lock = 4'b0010;
      run_frame(4'b0011, 0, 8'h10);
      run_frame(4'b0011, 1, 8'h11);
      run_frame(4'b0011, 1, 8'h11);
      run_frame(4'b0011, 1, 8'h11);
      bus.req_lock = '0;
      run_frame(4'b0011, 0, 8'h10);
      bus.req_valid = '0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
